io_timer_mcmp: RTL and testbench

Parametrised up-counting timer for the peripheral IO bus: CWidth-bit counter, CCmpCnt compare channels, periodic or one-shot mode. Channel 0 sets the period; channels 1..CCmpCnt-1 are match-only. Per-channel sticky flags and enables drive a single registered IRQ line into the interrupt controller. It supersedes the single-compare 16/32-bit timers and uses the same 1K/1M/CLK tick sources.

---
 rtl/io_timer_mcmp_if.sv | 21 ++
 rtl/io_timer_mcmp.sv | 173 +++++++++++++++++
 tb/tb_io_timer_mcmp.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/io_timer_mcmp_if.sv
// IO register bus between a bus master and the io_timer_mcmp peripheral.
// Address, write data and one-hot sizes flow master->slave; read data and decode status flow back.
interface io_timer_mcmp_if;
    logic [15:0] AIoAddr;
    logic [63:0] AIoMosi;
    logic [63:0] AIoMiso;
    logic [3:0]  AIoWrSize;
    logic [3:0]  AIoRdSize;
    logic        AIoAddrAck;
    logic        AIoAddrErr;

    modport master (
        output AIoAddr, AIoMosi, AIoWrSize, AIoRdSize,
        input  AIoMiso, AIoAddrAck, AIoAddrErr
    );

    modport slave (
        input  AIoAddr, AIoMosi, AIoWrSize, AIoRdSize,
        output AIoMiso, AIoAddrAck, AIoAddrErr
    );
endinterface

// File: rtl/io_timer_mcmp.sv
// Up-counting multi-compare timer on the IO bus: channel 0 sets the period, the others only match.
// Optional IO_TIMER_MCMP_CAPTURE_EN adds an ACapture input, a read-only Cap register and a capture flag.
module io_timer_mcmp #(
    parameter logic [15:0] CAddrBase = 16'h0000,
    parameter int unsigned CWidth    = 16,
    parameter int unsigned CCmpCnt   = 2
) (
    input  logic           AClkH,
    input  logic           AResetHN,
    input  logic           AClkHEn,
    io_timer_mcmp_if.slave AIo,
    input  logic           ASync1M,
    input  logic           ASync1K,
`ifdef IO_TIMER_MCMP_CAPTURE_EN
    input  logic           ACapture,
`endif
    output logic           AIrq,
    output logic [7:0]     ATest,
    output logic           AUnused
);

`ifdef IO_TIMER_MCMP_CAPTURE_EN
    localparam int unsigned CCapEn = 1;
`else
    localparam int unsigned CCapEn = 0;
`endif
    localparam int unsigned CFlagCnt = CCmpCnt + CCapEn;
    localparam int unsigned CRegCnt  = 4 + CCmpCnt + CCapEn;
    localparam logic [3:0]  CSzByte  = 4'b0001;
    localparam logic [3:0]  CSzWide  = (CWidth == 32) ? 4'b0100 : 4'b0010;

    typedef enum logic [1:0] {
        SrcOff = 2'b00,
        Src1K  = 2'b01,
        Src1M  = 2'b10,
        SrcClk = 2'b11
    } src_e;

    src_e                            src_q, src_d;
    logic                            oneshot_q, oneshot_d;
    logic [CFlagCnt-1:0]             stat_q, stat_d;
    logic [CFlagCnt-1:0]             irqen_q, irqen_d;
    logic [CWidth-1:0]               cnt_q, cnt_d;
    logic [CCmpCnt-1:0][CWidth-1:0]  cmp_q, cmp_d;
    logic                            irq_q, irq_d;

    logic [15:0]         off;
    logic                in_range, wr_acc, rd_acc, size_ok, we, re;
    logic [3:0]          exp_sz;
    logic [CWidth-1:0]   wdata;
    logic [63:0]         rdata;
    logic                tick;
    logic [CCmpCnt-1:0]  hit;

`ifdef IO_TIMER_MCMP_CAPTURE_EN
    logic              cap_s_q, cap_e_q, cap_rise;
    logic [CWidth-1:0] cap_q, cap_d;
    assign cap_rise = cap_s_q & ~cap_e_q;
`endif

    // Address decode: byte registers below index 3, CWidth-sized registers from 3 upwards.
    assign off      = AIo.AIoAddr - CAddrBase;
    assign in_range = (AIo.AIoAddr >= CAddrBase) && (off < 16'(CRegCnt));
    assign wr_acc   = |AIo.AIoWrSize;
    assign rd_acc   = |AIo.AIoRdSize;
    assign exp_sz   = (off < 16'd3) ? CSzByte : CSzWide;
    assign size_ok  = (!wr_acc || (AIo.AIoWrSize == exp_sz)) &&
                      (!rd_acc || (AIo.AIoRdSize == exp_sz));
    assign AIo.AIoAddrAck = in_range && (wr_acc || rd_acc) && size_ok;
    assign AIo.AIoAddrErr = in_range && (wr_acc || rd_acc) && !size_ok;
    assign we    = AIo.AIoAddrAck && wr_acc;
    assign re    = AIo.AIoAddrAck && rd_acc;
    assign wdata = AIo.AIoMosi[CWidth-1:0];

    always_comb begin
        rdata = '0;
        if (re) begin
            if (off == 16'd0) begin
                rdata[7:0] = {1'b0, oneshot_q, src_q, 4'b0000};
            end else if (off == 16'd1) begin
                rdata[CFlagCnt-1:0] = stat_q;
            end else if (off == 16'd2) begin
                rdata[CFlagCnt-1:0] = irqen_q;
            end else if (off == 16'd3) begin
                rdata[CWidth-1:0] = cnt_q;
            end
            for (int unsigned k = 0; k < CCmpCnt; k++) begin
                if (off == 16'(4 + k)) rdata[CWidth-1:0] = cmp_q[k];
            end
`ifdef IO_TIMER_MCMP_CAPTURE_EN
            if (off == 16'(4 + CCmpCnt)) rdata[CWidth-1:0] = cap_q;
`endif
        end
    end
    assign AIo.AIoMiso = rdata;

    assign tick = (src_q == SrcClk) || ((src_q == Src1M) && ASync1M) || ((src_q == Src1K) && ASync1K);

    always_comb begin
        for (int unsigned k = 0; k < CCmpCnt; k++) begin
            hit[k] = tick && (cnt_q == cmp_q[k]);
        end
    end

    // Later assignments override earlier ones: software writes beat the tick, hardware set beats clear.
    always_comb begin
        src_d     = src_q;
        oneshot_d = oneshot_q;
        stat_d    = stat_q;
        irqen_d   = irqen_q;
        cnt_d     = cnt_q;
        cmp_d     = cmp_q;
`ifdef IO_TIMER_MCMP_CAPTURE_EN
        cap_d     = cap_q;
`endif
        if (tick) cnt_d = hit[0] ? '0 : cnt_q + CWidth'(1);
        if (hit[0] && oneshot_q) src_d = SrcOff;
        if (we && (off == 16'd0)) begin
            src_d     = src_e'(wdata[5:4]);
            oneshot_d = wdata[6];
            if (wdata[1]) cnt_d = '0;
        end
        if (we && (off == 16'd3)) cnt_d = wdata;
        if (we && (off == 16'd2)) irqen_d = wdata[CFlagCnt-1:0];
        for (int unsigned k = 0; k < CCmpCnt; k++) begin
            if (we && (off == 16'(4 + k))) cmp_d[k] = wdata;
        end
        if (we && (off == 16'd1)) stat_d = stat_q & ~wdata[CFlagCnt-1:0];
        stat_d[CCmpCnt-1:0] = stat_d[CCmpCnt-1:0] | hit;
`ifdef IO_TIMER_MCMP_CAPTURE_EN
        if (cap_rise) begin
            cap_d           = cnt_q;
            stat_d[CCmpCnt] = 1'b1;
        end
`endif
        irq_d = |(stat_d & irqen_d);
    end

    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            src_q     <= SrcOff;
            oneshot_q <= 1'b0;
            stat_q    <= '0;
            irqen_q   <= '0;
            cnt_q     <= '0;
            cmp_q     <= '0;
            irq_q     <= 1'b0;
`ifdef IO_TIMER_MCMP_CAPTURE_EN
            cap_s_q   <= 1'b0;
            cap_e_q   <= 1'b0;
            cap_q     <= '0;
`endif
        end else if (AClkHEn) begin
            src_q     <= src_d;
            oneshot_q <= oneshot_d;
            stat_q    <= stat_d;
            irqen_q   <= irqen_d;
            cnt_q     <= cnt_d;
            cmp_q     <= cmp_d;
            irq_q     <= irq_d;
`ifdef IO_TIMER_MCMP_CAPTURE_EN
            cap_s_q   <= ACapture;
            cap_e_q   <= cap_s_q;
            cap_q     <= cap_d;
`endif
        end
    end

    assign AIrq    = irq_q;
    assign ATest   = {AClkH, tick, hit[0], |hit, |stat_q, irq_q, oneshot_q, src_q != SrcOff};
    assign AUnused = (|AIo.AIoMosi[63:CWidth]) | AIo.AIoWrSize[3] | AIo.AIoRdSize[3];

endmodule

// File: tb/tb_io_timer_mcmp.sv
// Scoreboard bench for io_timer_mcmp: a 16-bit instance at 0x0000 and a 32-bit one at 0x0100 share one bus.
// Stimulus queues expected values; the negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_io_timer_mcmp;
    typedef enum int {KMiso, KAck, KErr, KIrq} kind_e;
    typedef struct {
        int          dev;
        kind_e       kind;
        logic [63:0] exp;
        string       name;
    } chk_t;

    localparam logic [3:0] B = 4'b0001, W = 4'b0010, D = 4'b0100, N = 4'b0000;

    chk_t        sbq[$];
    chk_t        mon_c;
    logic [63:0] mon_act;
    int          ntests = 0;
    int          nfail  = 0;

    logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1, s1m = 1'b0, s1k = 1'b0, probe = 1'b0;
    logic       irq0, irq1, unused0, unused1;
    logic [7:0] test0, test1;

    io_timer_mcmp_if bus0();
    io_timer_mcmp_if bus1();

    always #5 clk = ~clk;

    io_timer_mcmp #(.CAddrBase(16'h0000), .CWidth(16), .CCmpCnt(2)) dut16 (
`ifdef IO_TIMER_MCMP_CAPTURE_EN
        .ACapture(1'b0),
`endif
        .AClkH(clk), .AResetHN(rst_n), .AClkHEn(clk_en), .AIo(bus0),
        .ASync1M(s1m), .ASync1K(s1k), .AIrq(irq0), .ATest(test0), .AUnused(unused0)
    );

    io_timer_mcmp #(.CAddrBase(16'h0100), .CWidth(32), .CCmpCnt(2)) dut32 (
`ifdef IO_TIMER_MCMP_CAPTURE_EN
        .ACapture(1'b0),
`endif
        .AClkH(clk), .AResetHN(rst_n), .AClkHEn(clk_en), .AIo(bus1),
        .ASync1M(s1m), .ASync1K(s1k), .AIrq(irq1), .ATest(test1), .AUnused(unused1)
    );

    always @(negedge clk) begin
        if (probe) begin
            ntests++;
            if (sbq.size() == 0) begin
                nfail++;
                $display("FAIL scoreboard_underflow: probe with no expected entry");
            end else begin
                mon_c = sbq.pop_front();
                case (mon_c.kind)
                    KMiso:   mon_act = (mon_c.dev == 0) ? bus0.AIoMiso : bus1.AIoMiso;
                    KAck:    mon_act = 64'((mon_c.dev == 0) ? bus0.AIoAddrAck : bus1.AIoAddrAck);
                    KErr:    mon_act = 64'((mon_c.dev == 0) ? bus0.AIoAddrErr : bus1.AIoAddrErr);
                    default: mon_act = 64'((mon_c.dev == 0) ? irq0 : irq1);
                endcase
                if (mon_act !== mon_c.exp) begin
                    nfail++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", mon_c.name, mon_act, mon_c.exp);
                end
            end
        end
    end

    // One bus cycle: drive at posedge+1, optionally queue a check sampled at the following negedge.
    task automatic op(input logic [15:0] addr, input logic [63:0] data, input logic [3:0] wsz,
                      input logic [3:0] rsz, input bit chk, input int dev, input kind_e kind,
                      input logic [63:0] exp, input string name);
        bus0.AIoAddr = addr;  bus1.AIoAddr = addr;
        bus0.AIoMosi = data;  bus1.AIoMosi = data;
        bus0.AIoWrSize = wsz; bus1.AIoWrSize = wsz;
        bus0.AIoRdSize = rsz; bus1.AIoRdSize = rsz;
        if (chk) begin
            sbq.push_back('{dev, kind, exp, name});
            probe = 1'b1;
        end
        @(posedge clk); #1;
        bus0.AIoWrSize = N; bus1.AIoWrSize = N;
        bus0.AIoRdSize = N; bus1.AIoRdSize = N;
        probe = 1'b0;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [63:0] data, input logic [3:0] sz);
        op(addr, data, sz, N, 1'b0, 0, KMiso, 64'd0, "");
    endtask

    task automatic rd(input int dev, input logic [15:0] addr, input logic [3:0] sz,
                      input logic [63:0] exp, input string name);
        op(addr, 64'd0, N, sz, 1'b1, dev, KMiso, exp, name);
    endtask

    task automatic chk_irq(input int dev, input logic exp, input string name);
        op(16'hFFFF, 64'd0, N, N, 1'b1, dev, KIrq, 64'(exp), name);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(16'hFFFF, 64'd0, N, N, 1'b0, 0, KMiso, 64'd0, "");
    endtask

    task automatic pulse1k();
        s1k = 1'b1;
        idle(1);
        s1k = 1'b0;
        idle(6);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus0.AIoAddr = 16'hFFFF; bus1.AIoAddr = 16'hFFFF;
        bus0.AIoMosi = '0;       bus1.AIoMosi = '0;
        bus0.AIoWrSize = N;      bus1.AIoWrSize = N;
        bus0.AIoRdSize = N;      bus1.AIoRdSize = N;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        rd(0, 16'h0000, B, 64'h00, "rst_ctrl");
        rd(0, 16'h0001, B, 64'h00, "rst_stat");
        rd(0, 16'h0003, W, 64'h0000, "rst_cnt");
        rd(0, 16'h0004, W, 64'h0000, "rst_cmp0");
        chk_irq(0, 1'b0, "rst_irq");

        // Periodic CLK source, Cmp0=4: period of 5 cycles
        wr(16'h0004, 64'd4, W);
        wr(16'h0005, 64'h00FF, W);
        wr(16'h0002, 64'h01, B);
        wr(16'h0000, 64'h30, B);
        for (int i = 0; i < 7; i++) rd(0, 16'h0003, W, 64'(i % 5), "p_cnt_seq");
        chk_irq(0, 1'b1, "p_irq_set");
        rd(0, 16'h0001, B, 64'h01, "p_stat_set");
        wr(16'h0001, 64'h01, B);
        chk_irq(0, 1'b1, "p_irq_hold_on_match");
        rd(0, 16'h0001, B, 64'h01, "p_stat_set_beats_clear");
        wr(16'h0001, 64'h01, B);
        chk_irq(0, 1'b0, "p_irq_clr");
        rd(0, 16'h0001, B, 64'h00, "p_stat_clr");
        chk_irq(0, 1'b1, "p_irq_rewrap");
        wr(16'h0003, 64'h1234, W);
        rd(0, 16'h0003, W, 64'h1234, "p_cnt_wr_beats_tick");
        rd(0, 16'h0003, W, 64'h1235, "p_cnt_after_wr");
        wr(16'h0000, 64'h00, B);
        rd(0, 16'h0003, W, 64'h1237, "p_cnt_stop");
        rd(0, 16'h0000, B, 64'h00, "p_ctrl_off");
        wr(16'h0000, 64'h02, B);
        rd(0, 16'h0003, W, 64'h0000, "p_cnt_clear");
        rd(0, 16'h0000, B, 64'h00, "p_ctrl_clear_reads0");
        wr(16'h0001, 64'h03, B);
        wr(16'h0002, 64'h00, B);

        // 1K source: Cmp1=3 matches on pulse 4, Cmp0=9 on pulse 10
        wr(16'h0004, 64'd9, W);
        wr(16'h0005, 64'd3, W);
        wr(16'h0000, 64'h12, B);
        for (int i = 0; i < 3; i++) pulse1k();
        rd(0, 16'h0001, B, 64'h00, "k_stat_p3");
        rd(0, 16'h0003, W, 64'd3, "k_cnt_p3");
        pulse1k();
        rd(0, 16'h0001, B, 64'h02, "k_stat_p4");
        rd(0, 16'h0003, W, 64'd4, "k_cnt_p4");
        for (int i = 0; i < 5; i++) pulse1k();
        rd(0, 16'h0003, W, 64'd9, "k_cnt_p9");
        rd(0, 16'h0001, B, 64'h02, "k_stat_p9");
        pulse1k();
        rd(0, 16'h0003, W, 64'd0, "k_cnt_p10");
        rd(0, 16'h0001, B, 64'h03, "k_stat_p10");
        chk_irq(0, 1'b0, "k_irq_masked");
        wr(16'h0002, 64'h02, B);
        chk_irq(0, 1'b1, "k_irq_enabled");
        wr(16'h0000, 64'h00, B);
        wr(16'h0001, 64'h03, B);
        wr(16'h0002, 64'h00, B);

        // One-shot, Cmp0=2: stops after the third tick
        wr(16'h0004, 64'd2, W);
        wr(16'h0000, 64'h72, B);
        idle(3);
        rd(0, 16'h0000, B, 64'h40, "o_ctrl_stopped");
        rd(0, 16'h0003, W, 64'd0, "o_cnt_zero");
        rd(0, 16'h0001, B, 64'h01, "o_stat0");
        idle(3);
        rd(0, 16'h0003, W, 64'd0, "o_cnt_held");
        wr(16'h0001, 64'h03, B);
        op(16'h0006, 64'd0, N, B, 1'b1, 0, KAck, 64'd0, "unmapped_ack");

        // 32-bit instance: size checking and all-ones wrap
        rd(1, 16'h0103, D, 64'd0, "w_cnt_rst");
        op(16'h0103, 64'hAB, B, N, 1'b1, 1, KErr, 64'd1, "w_err_byte");
        rd(1, 16'h0103, D, 64'd0, "w_cnt_unchanged");
        op(16'h0103, 64'd0, N, W, 1'b1, 1, KMiso, 64'd0, "w_miso_badsize");
        op(16'h0105, 64'd0, N, D, 1'b1, 1, KAck, 64'd1, "w_ack_dword");
        wr(16'h0105, 64'h100, D);
        wr(16'h0104, 64'h10, D);
        wr(16'h0103, 64'hFFFF_FFFF, D);
        wr(16'h0100, 64'h30, B);
        rd(1, 16'h0103, D, 64'hFFFF_FFFF, "w_cnt_allones");
        rd(1, 16'h0103, D, 64'd0, "w_cnt_wrap");
        rd(1, 16'h0101, B, 64'h00, "w_no_stat");
        wr(16'h0100, 64'h02, B);

        // Reset while counting with AIrq high
        wr(16'h0002, 64'h01, B);
        wr(16'h0000, 64'h32, B);
        idle(3);
        chk_irq(0, 1'b1, "r_irq_before");
        rst_n = 1'b0;
        chk_irq(0, 1'b0, "r_irq_reset");
        rd(0, 16'h0003, W, 64'd0, "r_cnt_reset");
        rd(0, 16'h0000, B, 64'h00, "r_ctrl_reset");
        rst_n = 1'b1;
        idle(3);
        rd(0, 16'h0003, W, 64'd0, "r_cnt_stays");

        idle(2);
        if (sbq.size() != 0) begin
            ntests++;
            nfail++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
